// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - N-digit packed-BCD up/down counter with programmable prescaler
// Optional saturating mode: define BCD_COUNTER_SAT_EN.
module bcd_updown_counter #(
  parameter int unsigned        DIGITS    = 4,
  parameter int unsigned        PRESC_W   = 32,
  parameter logic [PRESC_W-1:0] DIV_RESET = PRESC_W'(99_999_999)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Clear,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadVal,
  input  logic                  DivLoad,
  input  logic [PRESC_W-1:0]    Div,
  output logic [4*DIGITS-1:0]   BCDCount,
  output logic                  Tick,
  output logic                  Carry,
  output logic                  Borrow,
  output logic                  LoadErr
);

  localparam int unsigned W = 4 * DIGITS;

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] divider;
  logic [W-1:0]       step_val;
  logic               step_wrap;
  logic               load_ok;
  logic               at_term;

  // Ripple one step through the digits; a ripple out of the MSD means wrap.
  always_comb begin : step_logic
    logic       ripple;
    logic [3:0] digit;
    step_val = BCDCount;
    ripple   = 1'b1;
    digit    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = BCDCount[4*i +: 4];
      if (ripple) begin
        if (Up) begin
          if (digit >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            ripple             = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            ripple             = 1'b0;
          end
        end
      end
    end
    step_wrap = ripple;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (LoadVal[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // >= rather than == so a divider lowered below the running prescaler still fires.
  assign at_term = (presc >= divider);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      BCDCount <= '0;
      presc    <= '0;
      divider  <= DIV_RESET;
      Tick     <= 1'b0;
      Carry    <= 1'b0;
      Borrow   <= 1'b0;
      LoadErr  <= 1'b0;
    end else begin
      Tick    <= 1'b0;
      Carry   <= 1'b0;
      Borrow  <= 1'b0;
      LoadErr <= 1'b0;
      if (Clear) begin
        BCDCount <= '0;
        presc    <= '0;
      end else if (Load) begin
        presc <= '0;
        if (load_ok) begin
          BCDCount <= LoadVal;
        end else begin
          LoadErr <= 1'b1;
        end
      end else if (DivLoad) begin
        divider <= Div;
        presc   <= '0;
      end else if (En) begin
        if (at_term) begin
          presc  <= '0;
          Tick   <= 1'b1;
          Carry  <= step_wrap & Up;
          Borrow <= step_wrap & ~Up;
`ifdef BCD_COUNTER_SAT_EN
          if (!step_wrap) BCDCount <= step_val;
`else
          BCDCount <= step_val;
`endif
        end else begin
          presc <= presc + PRESC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - scoreboard bench for bcd_updown_counter
// Honours BCD_COUNTER_SAT_EN for the wrap-dependent expectations.
module tb_bcd_updown_counter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        En = 1'b0;
  logic        Up = 1'b1;
  logic        Clear = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] LoadVal = '0;
  logic        DivLoad = 1'b0;
  logic [31:0] Div = '0;
  logic [15:0] BCDCount;
  logic        Tick, Carry, Borrow, LoadErr;

  bcd_updown_counter #(.DIGITS(4), .PRESC_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Clear(Clear), .Load(Load),
    .LoadVal(LoadVal), .DivLoad(DivLoad), .Div(Div), .BCDCount(BCDCount),
    .Tick(Tick), .Carry(Carry), .Borrow(Borrow), .LoadErr(LoadErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        tick, carry, borrow, lerr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Each posedge (or reset assertion) consumes the expectation queued for it.
  initial begin
    forever begin
      @(posedge Clk or negedge Reset);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (BCDCount !== e.cnt || Tick !== e.tick || Carry !== e.carry ||
            Borrow !== e.borrow || LoadErr !== e.lerr) begin
          n_fail++;
          $display("FAIL %s: got cnt=%h t=%b c=%b b=%b le=%b, want cnt=%h t=%b c=%b b=%b le=%b",
                   e.name, BCDCount, Tick, Carry, Borrow, LoadErr,
                   e.cnt, e.tick, e.carry, e.borrow, e.lerr);
        end
      end
    end
  end

  task automatic set_in(input logic en, input logic up, input logic clr, input logic ld,
                        input logic [15:0] lv, input logic dl, input logic [31:0] dv);
    En = en; Up = up; Clear = clr; Load = ld; LoadVal = lv; DivLoad = dl; Div = dv;
  endtask

  task automatic chk(input string nm, input logic [15:0] c, input logic t,
                     input logic ca, input logic bo, input logic le);
    exp_t e;
    e.name = nm; e.cnt = c; e.tick = t; e.carry = ca; e.borrow = bo; e.lerr = le;
    q.push_back(e);
    @(negedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] seq [10];
  logic [15:0] prev;

  initial begin
    seq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
            16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h0010};
    @(negedge Clk);
    set_in(1, 1, 0, 0, 16'h0000, 0, 0);
    chk("rst_hold", 16'h0000, 0, 0, 0, 0);
    Reset = 1'b1;

    set_in(0, 1, 0, 0, 16'h0000, 1, 3);
    chk("divload3", 16'h0000, 0, 0, 0, 0);

    // Div=3: tick on every 4th enabled clock
    set_in(1, 1, 0, 0, 16'h0000, 0, 0);
    prev = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) chk("div3_wait", prev, 0, 0, 0, 0);
      chk("div3_tick", seq[i], 1, 0, 0, 0);
      prev = seq[i];
    end

    chk("en_pre1", 16'h0010, 0, 0, 0, 0);
    chk("en_pre2", 16'h0010, 0, 0, 0, 0);
    En = 1'b0;
    for (int k = 0; k < 5; k++) chk("en_off", 16'h0010, 0, 0, 0, 0);
    En = 1'b1;
    chk("en_resume1", 16'h0010, 0, 0, 0, 0);
    chk("en_resume2", 16'h0011, 1, 0, 0, 0);
    chk("mid_count", 16'h0011, 0, 0, 0, 0);

    // Asynchronous reset mid-count, checked before any clock edge
    begin
      exp_t e;
      e.name = "async_reset"; e.cnt = 16'h0000; e.tick = 0; e.carry = 0; e.borrow = 0; e.lerr = 0;
      q.push_back(e);
      En = 1'b0;
      Reset = 1'b0;
      #3;
      Reset = 1'b1;
      @(negedge Clk);
    end

    set_in(0, 1, 0, 0, 16'h0000, 1, 0);
    chk("divload0", 16'h0000, 0, 0, 0, 0);
    set_in(0, 1, 0, 1, 16'h9998, 0, 0);
    chk("load9998", 16'h9998, 0, 0, 0, 0);
    set_in(1, 1, 0, 0, 16'h0000, 0, 0);
    chk("up_9999", 16'h9999, 1, 0, 0, 0);
`ifdef BCD_COUNTER_SAT_EN
    chk("up_sat", 16'h9999, 1, 1, 0, 0);
    En = 1'b0;
    chk("carry_once", 16'h9999, 0, 0, 0, 0);
`else
    chk("up_wrap", 16'h0000, 1, 1, 0, 0);
    En = 1'b0;
    chk("carry_once", 16'h0000, 0, 0, 0, 0);
`endif

    set_in(0, 0, 0, 1, 16'h0001, 0, 0);
    chk("load0001", 16'h0001, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 16'h0000, 0, 0);
    chk("dn_0000", 16'h0000, 1, 0, 0, 0);
`ifdef BCD_COUNTER_SAT_EN
    chk("dn_sat", 16'h0000, 1, 0, 1, 0);
    Up = 1'b1;
    chk("up_after_sat", 16'h0001, 1, 0, 0, 0);
`else
    chk("dn_wrap", 16'h9999, 1, 0, 1, 0);
    Up = 1'b1;
    chk("up_after_wrap", 16'h0000, 1, 1, 0, 0);
`endif

    set_in(0, 1, 0, 1, 16'h4321, 0, 0);
    chk("load4321", 16'h4321, 0, 0, 0, 0);
    set_in(0, 1, 0, 1, 16'h12A4, 0, 0);
    chk("load_bad", 16'h4321, 0, 0, 0, 1);
    set_in(0, 1, 0, 0, 16'h0000, 0, 0);
    chk("lerr_once", 16'h4321, 0, 0, 0, 0);
    set_in(0, 1, 1, 1, 16'h12A4, 0, 0);
    chk("clear_over_load", 16'h0000, 0, 0, 0, 0);

    set_in(0, 1, 0, 1, 16'h1000, 0, 0);
    chk("load1000", 16'h1000, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 16'h0000, 0, 0);
    chk("dn_ripple", 16'h0999, 1, 0, 0, 0);
    Up = 1'b1;
    chk("up_ripple", 16'h1000, 1, 0, 0, 0);

    // Up sampled only on the tick cycle
    set_in(0, 0, 0, 0, 16'h0000, 1, 3);
    chk("divload3b", 16'h1000, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 16'h0000, 0, 0);
    chk("updn_w1", 16'h1000, 0, 0, 0, 0);
    chk("updn_w2", 16'h1000, 0, 0, 0, 0);
    Up = 1'b1;
    chk("updn_w3", 16'h1000, 0, 0, 0, 0);
    chk("updn_tick", 16'h1001, 1, 0, 0, 0);

    set_in(0, 1, 0, 0, 16'h0000, 0, 0);
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
